// File: rtl/riscv_decode_operand_stage.sv
// rtl/riscv_decode_operand_stage.sv - RV32I decode stage producing registered control flags, ALU opcode and operands
module riscv_decode_operand_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] a_data,
  output logic [XLEN-1:0] b_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            should_read_mem,
  output logic            should_write_mem,
  output logic            should_write_reg,
  output logic            should_branch,
  output logic            should_jump,
  output logic            branch_negate,
  output logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] jump_offset,
  output logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      mem_funct3,
  output logic            illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;

  localparam logic [4:0] OPC_LOAD   = 5'h00;
  localparam logic [4:0] OPC_FENCE  = 5'h03;
  localparam logic [4:0] OPC_OPIMM  = 5'h04;
  localparam logic [4:0] OPC_AUIPC  = 5'h05;
  localparam logic [4:0] OPC_STORE  = 5'h08;
  localparam logic [4:0] OPC_OP     = 5'h0c;
  localparam logic [4:0] OPC_LUI    = 5'h0d;
  localparam logic [4:0] OPC_BRANCH = 5'h18;
  localparam logic [4:0] OPC_JALR   = 5'h19;
  localparam logic [4:0] OPC_JAL    = 5'h1b;

  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_b, imm_j, shamt;
  logic [3:0]      d_alu_op;
  logic [XLEN-1:0] d_a, d_b;
  logic            d_read_mem, d_write_mem, d_write_reg, d_branch, d_jump;
  logic            d_negate, d_illegal;
  logic            unused_opcode_low;

  // opcode[1:0] carries no information for this decoder
  assign unused_opcode_low = ^instr[1:0];

  assign funct3 = instr[14:12];
  assign alt    = instr[30];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt  = {27'b0, instr[24:20]};

  // funct3 -> ALU op shared by op-imm and op; only register ops use bit 30 to select sub
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sel_alt, input logic is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_reg && sel_alt) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = sel_alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // combinational decode of the instruction presented this cycle
  always_comb begin
    d_alu_op    = ALU_ADD;
    d_a         = '0;
    d_b         = '0;
    d_read_mem  = 1'b0;
    d_write_mem = 1'b0;
    d_write_reg = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_negate    = 1'b0;
    d_illegal   = 1'b0;
    case (instr[6:2])
      OPC_LOAD: begin
        d_a = rs1_data; d_b = imm_i; d_read_mem = 1'b1; d_write_reg = 1'b1;
      end
      OPC_FENCE: begin
        d_a = rs1_data; d_b = imm_i;
      end
      OPC_OPIMM: begin
        d_alu_op    = arith_op(funct3, alt, 1'b0);
        d_a         = rs1_data;
        d_b         = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt : imm_i;
        d_write_reg = 1'b1;
      end
      OPC_AUIPC: begin
        d_a = pc; d_b = imm_u; d_write_reg = 1'b1;
      end
      OPC_STORE: begin
        d_a = rs1_data; d_b = imm_s; d_write_mem = 1'b1;
      end
      OPC_OP: begin
        d_alu_op    = arith_op(funct3, alt, 1'b1);
        d_a         = rs1_data;
        d_b         = rs2_data;
        d_write_reg = 1'b1;
      end
      OPC_LUI: begin
        d_b = imm_u; d_write_reg = 1'b1;
      end
      OPC_BRANCH: begin
        // 010/011 are not branches; they fall out as illegal with zero operands
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          d_illegal = 1'b1;
        end else begin
          d_a      = rs1_data;
          d_b      = rs2_data;
          d_branch = 1'b1;
          case (funct3[2:1])
            2'b00:   d_alu_op = ALU_SUB;
            2'b10:   d_alu_op = ALU_SLT;
            default: d_alu_op = ALU_SLTU;
          endcase
          // eq compares via sub (taken on zero); lt variants are taken on a nonzero compare
          d_negate = funct3[2] ? ~funct3[0] : funct3[0];
        end
      end
      OPC_JALR: begin
        d_a = rs1_data; d_b = imm_i; d_jump = 1'b1; d_write_reg = 1'b1;
      end
      OPC_JAL: begin
        d_a = pc; d_b = imm_j; d_jump = 1'b1; d_write_reg = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // output register: capture on in_valid, otherwise drop valid and control flags and hold the rest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid        <= 1'b0;
      alu_op           <= ALU_ADD;
      a_data           <= '0;
      b_data           <= '0;
      rs1_addr         <= '0;
      rs2_addr         <= '0;
      rd_addr          <= '0;
      should_read_mem  <= 1'b0;
      should_write_mem <= 1'b0;
      should_write_reg <= 1'b0;
      should_branch    <= 1'b0;
      should_jump      <= 1'b0;
      branch_negate    <= 1'b0;
      branch_offset    <= '0;
      jump_offset      <= '0;
      link_addr        <= '0;
      out_pc           <= RESET_PC;
      mem_funct3       <= '0;
      illegal          <= 1'b0;
    end else if (in_valid) begin
      out_valid        <= 1'b1;
      alu_op           <= d_alu_op;
      a_data           <= d_a;
      b_data           <= d_b;
      rs1_addr         <= instr[19:15];
      rs2_addr         <= instr[24:20];
      rd_addr          <= instr[11:7];
      should_read_mem  <= d_read_mem;
      should_write_mem <= d_write_mem;
      should_write_reg <= d_write_reg;
      should_branch    <= d_branch;
      should_jump      <= d_jump;
      branch_negate    <= d_negate;
      branch_offset    <= imm_b;
      jump_offset      <= imm_j;
      link_addr        <= pc + 32'd4;
      out_pc           <= pc;
      mem_funct3       <= funct3;
      illegal          <= d_illegal;
    end else begin
      out_valid        <= 1'b0;
      should_read_mem  <= 1'b0;
      should_write_mem <= 1'b0;
      should_write_reg <= 1'b0;
      should_branch    <= 1'b0;
      should_jump      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_decode_operand_stage.sv
// tb/tb_riscv_decode_operand_stage.sv - randomized self-checking bench for riscv_decode_operand_stage
module tb_riscv_decode_operand_stage;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SLL = 4'b0100, SRL = 4'b0110;
  localparam logic [3:0] SRA = 4'b0111, AND = 4'b1001, OR = 4'b1010, XOR = 4'b1011;
  localparam logic [3:0] SLTU = 4'b1100, SLT = 4'b1101;

  localparam logic [3:0] OPMAP  [8] = '{ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND};
  localparam logic [3:0] BR_OP  [8] = '{SUB, SUB, ADD, ADD, SLT, SLT, SLTU, SLTU};
  localparam logic       BR_NEG [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic       BR_OK  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [4:0] OPCODES [10] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08,
                                          5'h0c, 5'h0d, 5'h18, 5'h19, 5'h1b};

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a, b, boff, joff, link, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rm, wm, wr, br, jp, neg, ill;
    logic [2:0]  f3;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic        out_valid;
  logic [3:0]  alu_op;
  logic [31:0] a_data, b_data, branch_offset, jump_offset, link_addr, out_pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        should_read_mem, should_write_mem, should_write_reg, should_branch, should_jump;
  logic        branch_negate, illegal;
  logic [2:0]  mem_funct3;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_s;

  riscv_decode_operand_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .alu_op(alu_op),
    .a_data(a_data), .b_data(b_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .should_read_mem(should_read_mem), .should_write_mem(should_write_mem),
    .should_write_reg(should_write_reg), .should_branch(should_branch),
    .should_jump(should_jump), .branch_negate(branch_negate), .branch_offset(branch_offset),
    .jump_offset(jump_offset), .link_addr(link_addr), .out_pc(out_pc),
    .mem_funct3(mem_funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got=%h want=%h", tag, got, want);
    else n_pass++;
  endtask

  function automatic exp_t reset_state();
    exp_t e = '{default: 0};
    return e;
  endfunction

  // reference decode computed straight from the instruction-set rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e = '{default: 0};
    int          f3 = int'(ins[14:12]);
    logic [31:0] ii, ss, uu;
    ii = 32'($signed(ins) >>> 20);
    ss = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    uu = ins & 32'hFFFFF000;
    e.v    = 1'b1;
    e.op   = ADD;
    e.rs1  = ins[19:15];
    e.rs2  = ins[24:20];
    e.rd   = ins[11:7];
    e.f3   = ins[14:12];
    e.pc   = p;
    e.link = p + 32'd4;
    e.boff = (ins[31] ? 32'hFFFFF000 : 32'h0) | (32'(ins[7]) << 11) |
             (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    e.joff = (ins[31] ? 32'hFFF00000 : 32'h0) | (32'(ins[19:12]) << 12) |
             (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    case (ins[6:2])
      5'h00: begin e.a = r1; e.b = ii; e.rm = 1; e.wr = 1; end
      5'h03: begin e.a = r1; e.b = ii; end
      5'h04: begin
        e.a = r1; e.wr = 1; e.op = OPMAP[f3];
        if (f3 == 5 && ins[30]) e.op = SRA;
        e.b = (f3 == 1 || f3 == 5) ? ((ins >> 20) & 32'd31) : ii;
      end
      5'h05: begin e.a = p; e.b = uu; e.wr = 1; end
      5'h08: begin e.a = r1; e.b = ss; e.wm = 1; end
      5'h0c: begin
        e.a = r1; e.b = r2; e.wr = 1; e.op = OPMAP[f3];
        if (f3 == 0 && ins[30]) e.op = SUB;
        if (f3 == 5 && ins[30]) e.op = SRA;
      end
      5'h0d: begin e.b = uu; e.wr = 1; end
      5'h18: begin
        if (BR_OK[f3]) begin
          e.a = r1; e.b = r2; e.br = 1; e.op = BR_OP[f3]; e.neg = BR_NEG[f3];
        end else e.ill = 1;
      end
      5'h19: begin e.a = r1; e.b = ii; e.jp = 1; e.wr = 1; end
      5'h1b: begin e.a = p; e.b = e.joff; e.jp = 1; e.wr = 1; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_s.v));
    check({tag, ".alu_op"}, 32'(alu_op), 32'(exp_s.op));
    check({tag, ".a"}, a_data, exp_s.a);
    check({tag, ".b"}, b_data, exp_s.b);
    check({tag, ".regs"}, {17'b0, rs1_addr, rs2_addr, rd_addr}, {17'b0, exp_s.rs1, exp_s.rs2, exp_s.rd});
    check({tag, ".flags"},
          {25'b0, should_read_mem, should_write_mem, should_write_reg, should_branch, should_jump, branch_negate, illegal},
          {25'b0, exp_s.rm, exp_s.wm, exp_s.wr, exp_s.br, exp_s.jp, exp_s.neg, exp_s.ill});
    check({tag, ".boff"}, branch_offset, exp_s.boff);
    check({tag, ".joff"}, jump_offset, exp_s.joff);
    check({tag, ".link"}, link_addr, exp_s.link);
    check({tag, ".pc"}, out_pc, exp_s.pc);
    check({tag, ".f3"}, 32'(mem_funct3), 32'(exp_s.f3));
  endtask

  // drive one cycle of input at the falling edge, then check after the next capture edge
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] p, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
    if (v) exp_s = model(ins, p, r1, r2);
    else begin
      exp_s.v = 0; exp_s.rm = 0; exp_s.wm = 0; exp_s.wr = 0; exp_s.br = 0; exp_s.jp = 0;
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  opc;
    reset = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    exp_s = reset_state();
    @(negedge clk);
    compare_all("reset");
    reset = 1'b1;

    step("addi", 1, 32'hFFF10093, 32'h100, 32'd5, 32'd0);
    check("addi_b_const", b_data, 32'hFFFFFFFF);
    check("addi_rd_const", 32'(rd_addr), 32'd1);
    step("sub", 1, 32'h402081B3, 32'h104, 32'd9, 32'd4);
    check("sub_op_const", 32'(alu_op), 32'h1);
    step("lui", 1, 32'h123452B7, 32'h108, 32'h55, 32'h66);
    check("lui_b_const", b_data, 32'h12345000);
    step("sw", 1, 32'h0020A423, 32'h10c, 32'h1000, 32'h77);
    check("sw_b_const", b_data, 32'd8);
    step("bne", 1, 32'h00209463, 32'h110, 32'd3, 32'd3);
    check("bne_off_const", branch_offset, 32'd8);
    step("idle", 0, 32'h0, 32'h0, 32'h0, 32'h0);
    step("illegal", 1, 32'h0000007F, 32'h114, 32'h1, 32'h2);
    check("illegal_const", 32'(illegal), 32'd1);

    // asynchronous reset between clock edges
    #3 reset = 1'b0;
    #1 exp_s = reset_state();
    compare_all("async_reset");
    @(negedge clk);
    compare_all("held_reset");
    reset = 1'b1;
    step("post_reset_idle", 0, 32'h00209463, 32'h200, 32'h1, 32'h2);
    step("post_reset_cap", 1, 32'h00209463, 32'h200, 32'h1, 32'h2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      opc = ($urandom_range(0, 9) < 8) ? OPCODES[$urandom_range(0, 9)] : 5'($urandom());
      step("rand", ($urandom_range(0, 7) != 0), {r[31:7], opc, r[1:0]},
           $urandom(), $urandom(), $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
